// File: rtl/kicp_sram_arbiter.sv
// Two-requester arbiter for the single-port KICP SRAM.
// Serves one transaction at a time and breaks ties round-robin between the Wishbone controller and the engine.
`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 10
`endif

module kicp_sram_arbiter #(
   parameter int AWIDTH     = `KICP_SRAM_AWIDTH,
   parameter int DWIDTH     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        wb_mem_op,
   input  logic [AWIDTH-1:0] wb_mem_addr,
   input  logic [DWIDTH-1:0] wb_mem_data,
   output logic              wb_mem_opdone,
   output logic [DWIDTH-1:0] wb_mem_rdata,
   input  logic [1:0]        eng_mem_op,
   input  logic [AWIDTH-1:0] eng_mem_addr,
   input  logic [DWIDTH-1:0] eng_mem_data,
   output logic              eng_mem_opdone,
   output logic [DWIDTH-1:0] eng_mem_rdata,
   output logic              sram_en,
   output logic              sram_we,
   output logic [AWIDTH-1:0] sram_addr,
   output logic [DWIDTH-1:0] sram_wdata,
   input  logic [DWIDTH-1:0] sram_rdata,
   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

   state_t     state;
   logic       last_eng;
   logic       op_write;
   logic [1:0] wait_cnt;
   logic       wb_req;
   logic       eng_req;
   logic       pick_eng;

   // Codes 01 and 11 are requests; bit 0 alone identifies them, so 10 is never seen as valid.
   assign wb_req   = wb_mem_op[0];
   assign eng_req  = eng_mem_op[0];
   assign pick_eng = eng_req && (!wb_req || !last_eng);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         last_eng       <= 1'b1;
         op_write       <= 1'b0;
         wait_cnt       <= 2'd0;
         wb_mem_opdone  <= 1'b0;
         wb_mem_rdata   <= '0;
         eng_mem_opdone <= 1'b0;
         eng_mem_rdata  <= '0;
         sram_en        <= 1'b0;
         sram_we        <= 1'b0;
         sram_addr      <= '0;
         sram_wdata     <= '0;
         grant          <= 2'b00;
         busy           <= 1'b0;
      end else begin
         wb_mem_opdone  <= 1'b0;
         eng_mem_opdone <= 1'b0;
         sram_en        <= 1'b0;
         sram_we        <= 1'b0;
         case (state)
            IDLE: begin
               if (wb_req || eng_req) begin
                  state   <= ISSUE;
                  busy    <= 1'b1;
                  sram_en <= 1'b1;
                  if (pick_eng) begin
                     grant      <= 2'b10;
                     last_eng   <= 1'b1;
                     op_write   <= eng_mem_op[1];
                     sram_we    <= eng_mem_op[1];
                     sram_addr  <= eng_mem_addr;
                     sram_wdata <= eng_mem_data;
                  end else begin
                     grant      <= 2'b01;
                     last_eng   <= 1'b0;
                     op_write   <= wb_mem_op[1];
                     sram_we    <= wb_mem_op[1];
                     sram_addr  <= wb_mem_addr;
                     sram_wdata <= wb_mem_data;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= 2'd0;
               if (op_write) begin
                  state          <= DONE;
                  wb_mem_opdone  <= grant[0];
                  eng_mem_opdone <= grant[1];
               end else begin
                  state <= WAIT;
               end
            end
            // Read data is valid in the last WAIT cycle and is captured on the edge leaving it.
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state          <= DONE;
                  wb_mem_opdone  <= grant[0];
                  eng_mem_opdone <= grant[1];
                  if (grant[1]) begin
                     eng_mem_rdata <= sram_rdata;
                  end else begin
                     wb_mem_rdata <= sram_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               grant <= 2'b00;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kicp_sram_arbiter.sv
// Directed bench for kicp_sram_arbiter: one instance with RD_LATENCY=1, one with RD_LATENCY=3,
// each backed by a behavioural SRAM whose read data is valid only in the exact latency cycle.
module tb_kicp_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;

   logic [1:0]  wb_mem_op, eng_mem_op;
   logic [7:0]  wb_mem_addr, eng_mem_addr;
   logic [31:0] wb_mem_data, eng_mem_data;
   logic        wb_mem_opdone, eng_mem_opdone;
   logic [31:0] wb_mem_rdata, eng_mem_rdata;
   logic        sram_en, sram_we;
   logic [7:0]  sram_addr;
   logic [31:0] sram_wdata, sram_rdata;
   logic [1:0]  grant;
   logic        busy;

   logic [1:0]  d3_wb_op, d3_eng_op;
   logic [7:0]  d3_wb_addr, d3_eng_addr;
   logic [31:0] d3_wb_data, d3_eng_data;
   logic        d3_wb_opdone, d3_eng_opdone;
   logic [31:0] d3_wb_rdata, d3_eng_rdata;
   logic        d3_sram_en, d3_sram_we;
   logic [7:0]  d3_sram_addr;
   logic [31:0] d3_sram_wdata, d3_sram_rdata;
   logic [1:0]  d3_grant;
   logic        d3_busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   kicp_sram_arbiter #(.AWIDTH(8), .DWIDTH(32), .RD_LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .wb_mem_op(wb_mem_op), .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
      .wb_mem_opdone(wb_mem_opdone), .wb_mem_rdata(wb_mem_rdata),
      .eng_mem_op(eng_mem_op), .eng_mem_addr(eng_mem_addr), .eng_mem_data(eng_mem_data),
      .eng_mem_opdone(eng_mem_opdone), .eng_mem_rdata(eng_mem_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .grant(grant), .busy(busy)
   );

   kicp_sram_arbiter #(.AWIDTH(8), .DWIDTH(32), .RD_LATENCY(3)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .wb_mem_op(d3_wb_op), .wb_mem_addr(d3_wb_addr), .wb_mem_data(d3_wb_data),
      .wb_mem_opdone(d3_wb_opdone), .wb_mem_rdata(d3_wb_rdata),
      .eng_mem_op(d3_eng_op), .eng_mem_addr(d3_eng_addr), .eng_mem_data(d3_eng_data),
      .eng_mem_opdone(d3_eng_opdone), .eng_mem_rdata(d3_eng_rdata),
      .sram_en(d3_sram_en), .sram_we(d3_sram_we), .sram_addr(d3_sram_addr),
      .sram_wdata(d3_sram_wdata), .sram_rdata(d3_sram_rdata),
      .grant(d3_grant), .busy(d3_busy)
   );

   // SRAM models; outside the exact latency cycle the read bus carries a poison value.
   logic [31:0] mem1 [0:255];
   logic [31:0] rd1;
   always @(posedge clk) begin
      if (!reset_n) mem1[1] <= 32'h1111_1111;
      if (sram_en) begin
         if (sram_we) mem1[sram_addr] <= sram_wdata;
         rd1 <= mem1[sram_addr];
      end else begin
         rd1 <= 32'h0BAD_0BAD;
      end
   end
   assign sram_rdata = rd1;

   logic [31:0] mem3 [0:255];
   logic [31:0] q0, q1, q2;
   always @(posedge clk) begin
      if (!reset_n) mem3[7] <= 32'hCAFE_F00D;
      if (d3_sram_en) begin
         if (d3_sram_we) mem3[d3_sram_addr] <= d3_sram_wdata;
         q0 <= mem3[d3_sram_addr];
      end else begin
         q0 <= 32'h0BAD_0BAD;
      end
      q1 <= q0;
      q2 <= q1;
   end
   assign d3_sram_rdata = q2;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      wb_mem_op = 2'b00; wb_mem_addr = '0; wb_mem_data = '0;
      eng_mem_op = 2'b00; eng_mem_addr = '0; eng_mem_data = '0;
      d3_wb_op = 2'b00; d3_wb_addr = '0; d3_wb_data = '0;
      d3_eng_op = 2'b00; d3_eng_addr = '0; d3_eng_data = '0;
      step; step;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %0h want 0", busy); end
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant got %0h want 0", grant); end
      vectors++; if ({sram_en, sram_we} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_sram_ctl got %0h want 0", {sram_en, sram_we}); end
      vectors++; if ({sram_addr, sram_wdata} !== 40'h0) begin miscompares++; $display("[TB] FAIL reset_sram_bus got %0h want 0", {sram_addr, sram_wdata}); end
      vectors++; if ({wb_mem_opdone, eng_mem_opdone} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_opdone got %0h want 0", {wb_mem_opdone, eng_mem_opdone}); end
      vectors++; if ({wb_mem_rdata, eng_mem_rdata} !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_rdata got %0h want 0", {wb_mem_rdata, eng_mem_rdata}); end
      vectors++; if ({d3_busy, d3_grant, d3_sram_en} !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_dut3 got %0h want 0", {d3_busy, d3_grant, d3_sram_en}); end
      reset_n = 1'b1;
      step;
   endtask

   task automatic test_single_write;
      wb_mem_op = 2'b11; wb_mem_addr = 8'd5; wb_mem_data = 32'hDEAD_BEEF;
      step;
      vectors++; if ({sram_en, sram_we} !== 2'b11) begin miscompares++; $display("[TB] FAIL wr_issue_ctl got %0h want 3", {sram_en, sram_we}); end
      vectors++; if (sram_addr !== 8'd5) begin miscompares++; $display("[TB] FAIL wr_issue_addr got %0h want 5", sram_addr); end
      vectors++; if (sram_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_issue_wdata got %0h want deadbeef", sram_wdata); end
      vectors++; if ({grant, busy, wb_mem_opdone} !== 4'b0110) begin miscompares++; $display("[TB] FAIL wr_issue_grant got %0h want 6", {grant, busy, wb_mem_opdone}); end
      step;
      vectors++; if ({wb_mem_opdone, eng_mem_opdone, sram_en} !== 3'b100) begin miscompares++; $display("[TB] FAIL wr_done got %0h want 4", {wb_mem_opdone, eng_mem_opdone, sram_en}); end
      wb_mem_op = 2'b00;
      step;
      vectors++; if ({wb_mem_opdone, busy, grant} !== 4'b0000) begin miscompares++; $display("[TB] FAIL wr_idle got %0h want 0", {wb_mem_opdone, busy, grant}); end
      vectors++; if (mem1[5] !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_mem got %0h want deadbeef", mem1[5]); end
   endtask

   task automatic test_read_l1;
      eng_mem_op = 2'b01; eng_mem_addr = 8'd5;
      step;
      vectors++; if ({sram_en, sram_we, grant} !== 4'b1010) begin miscompares++; $display("[TB] FAIL rd1_issue got %0h want a", {sram_en, sram_we, grant}); end
      vectors++; if (sram_addr !== 8'd5) begin miscompares++; $display("[TB] FAIL rd1_addr got %0h want 5", sram_addr); end
      step;
      vectors++; if ({sram_en, eng_mem_opdone, busy} !== 3'b001) begin miscompares++; $display("[TB] FAIL rd1_wait got %0h want 1", {sram_en, eng_mem_opdone, busy}); end
      step;
      vectors++; if ({eng_mem_opdone, wb_mem_opdone} !== 2'b10) begin miscompares++; $display("[TB] FAIL rd1_done got %0h want 2", {eng_mem_opdone, wb_mem_opdone}); end
      vectors++; if (eng_mem_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd1_eng_rdata got %0h want deadbeef", eng_mem_rdata); end
      vectors++; if (wb_mem_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rd1_wb_rdata got %0h want 0", wb_mem_rdata); end
      eng_mem_op = 2'b00;
      step;
      vectors++; if ({eng_mem_opdone, busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL rd1_idle got %0h want 0", {eng_mem_opdone, busy}); end
      vectors++; if (eng_mem_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd1_hold got %0h want deadbeef", eng_mem_rdata); end
   endtask

   task automatic test_round_robin;
      reset_n = 1'b0;
      step;
      reset_n = 1'b1;
      wb_mem_op = 2'b01; wb_mem_addr = 8'd1;
      eng_mem_op = 2'b11; eng_mem_addr = 8'd2; eng_mem_data = 32'h2222_2222;
      for (int k = 0; k < 4; k++) begin
         logic exp_wb;
         int n;
         exp_wb = (k % 2 == 0);
         n = 0;
         while (sram_en !== 1'b1 && n < 8) begin step; n++; end
         vectors++; if (n >= 8) begin miscompares++; $display("[TB] FAIL rr_issue_timeout got %0d want <8", n); end
         vectors++; if (grant !== (exp_wb ? 2'b01 : 2'b10)) begin miscompares++; $display("[TB] FAIL rr_grant%0d got %0h want %0h", k, grant, exp_wb ? 2'b01 : 2'b10); end
         vectors++; if (sram_addr !== (exp_wb ? 8'd1 : 8'd2)) begin miscompares++; $display("[TB] FAIL rr_addr%0d got %0h want %0h", k, sram_addr, exp_wb ? 8'd1 : 8'd2); end
         n = 0;
         while (wb_mem_opdone !== 1'b1 && eng_mem_opdone !== 1'b1 && n < 8) begin step; n++; end
         vectors++; if ({wb_mem_opdone, eng_mem_opdone} !== {exp_wb, ~exp_wb}) begin miscompares++; $display("[TB] FAIL rr_opdone%0d got %0h want %0h", k, {wb_mem_opdone, eng_mem_opdone}, {exp_wb, ~exp_wb}); end
         if (k == 0) begin
            vectors++; if (wb_mem_rdata !== 32'h1111_1111) begin miscompares++; $display("[TB] FAIL rr_wb_rdata got %0h want 11111111", wb_mem_rdata); end
         end
         step;
      end
      wb_mem_op = 2'b00; eng_mem_op = 2'b00;
      step;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_idle got %0h want 0", busy); end
      vectors++; if (mem1[2] !== 32'h2222_2222) begin miscompares++; $display("[TB] FAIL rr_mem got %0h want 22222222", mem1[2]); end
   endtask

   task automatic test_reset_in_wait;
      // After the engine won last, this wb read is dropped in WAIT; reset must re-arm wb priority.
      wb_mem_op = 2'b01; wb_mem_addr = 8'd1;
      step;
      vectors++; if (grant !== 2'b01) begin miscompares++; $display("[TB] FAIL rw_grant got %0h want 1", grant); end
      step;
      reset_n = 1'b0;
      wb_mem_op = 2'b00;
      step;
      vectors++; if ({wb_mem_opdone, eng_mem_opdone, busy, grant, sram_en} !== 6'b0) begin miscompares++; $display("[TB] FAIL rw_ctl got %0h want 0", {wb_mem_opdone, eng_mem_opdone, busy, grant, sram_en}); end
      vectors++; if (wb_mem_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rw_rdata got %0h want 0", wb_mem_rdata); end
      reset_n = 1'b1;
      wb_mem_op = 2'b11; wb_mem_addr = 8'd3; wb_mem_data = 32'h3333_3333;
      eng_mem_op = 2'b11; eng_mem_addr = 8'd4; eng_mem_data = 32'h4444_4444;
      step;
      vectors++; if ({grant, wb_mem_opdone} !== 3'b010) begin miscompares++; $display("[TB] FAIL rw_tie_grant got %0h want 2", {grant, wb_mem_opdone}); end
      step;
      vectors++; if ({wb_mem_opdone, eng_mem_opdone} !== 2'b10) begin miscompares++; $display("[TB] FAIL rw_wb_done got %0h want 2", {wb_mem_opdone, eng_mem_opdone}); end
      wb_mem_op = 2'b00;
      step;
      step;
      vectors++; if ({grant, sram_addr} !== {2'b10, 8'd4}) begin miscompares++; $display("[TB] FAIL rw_eng_grant got %0h want 204", {grant, sram_addr}); end
      step;
      vectors++; if ({wb_mem_opdone, eng_mem_opdone} !== 2'b01) begin miscompares++; $display("[TB] FAIL rw_eng_done got %0h want 1", {wb_mem_opdone, eng_mem_opdone}); end
      eng_mem_op = 2'b00;
      step;
   endtask

   task automatic test_op10;
      wb_mem_op = 2'b10; wb_mem_addr = 8'd9;
      for (int c = 0; c < 10; c++) begin
         step;
         vectors++; if ({busy, sram_en, grant} !== 4'b0000) begin miscompares++; $display("[TB] FAIL op10_c%0d got %0h want 0", c, {busy, sram_en, grant}); end
      end
      wb_mem_op = 2'b00;
   endtask

   task automatic test_rd_latency3;
      int en_count;
      en_count = 0;
      d3_wb_op = 2'b01; d3_wb_addr = 8'd7;
      for (int c = 1; c <= 6; c++) begin
         step;
         if (d3_sram_en === 1'b1) en_count++;
         vectors++; if ({d3_sram_en, d3_wb_opdone} !== {(c == 1), (c == 5)}) begin miscompares++; $display("[TB] FAIL rd3_c%0d got %0h want %0h", c, {d3_sram_en, d3_wb_opdone}, {(c == 1), (c == 5)}); end
         if (c == 5) begin
            vectors++; if (d3_wb_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL rd3_rdata got %0h want cafef00d", d3_wb_rdata); end
            d3_wb_op = 2'b00;
         end
      end
      vectors++; if (en_count !== 1) begin miscompares++; $display("[TB] FAIL rd3_en_count got %0d want 1", en_count); end
      vectors++; if ({d3_busy, d3_eng_rdata} !== 33'h0) begin miscompares++; $display("[TB] FAIL rd3_idle got %0h want 0", {d3_busy, d3_eng_rdata}); end
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_read_l1;
      test_round_robin;
      test_reset_in_wait;
      test_op10;
      test_rd_latency3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/kicp_sram_arbiter.md
Name: kicp_sram_arbiter

Overview:
- Shares the single-port KICP SRAM between two requesters: the Wishbone slave controller (wbctrl_mem_* port) and the compute engine (eng_mem_* port).
- Each requester uses the 2-bit op handshake: 01 read, 11 write, 00 none. The op is held until a one-cycle opdone pulse is returned.
- Round-robin arbitration on ties. One transaction in flight at a time.
- Drives the SRAM macro's enable, write-enable, address and write-data pins, and returns read data to the granted requester.

Parameters:
- AWIDTH, `KICP_SRAM_AWIDTH, SRAM word-address width.
- DWIDTH, 32, data width.
- RD_LATENCY, 1, cycles from the SRAM enable edge to valid sram_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock (the Wishbone clock).
- reset_n  in  1  synchronous, active-low reset.
- wb_mem_op  in  2  Wishbone-controller request op.
- wb_mem_addr  in  AWIDTH  Wishbone-controller word address.
- wb_mem_data  in  DWIDTH  Wishbone-controller write data.
- wb_mem_opdone  out  1  completion pulse to the Wishbone controller.
- wb_mem_rdata  out  DWIDTH  read data to the Wishbone controller.
- eng_mem_op  in  2  engine request op.
- eng_mem_addr  in  AWIDTH  engine word address.
- eng_mem_data  in  DWIDTH  engine write data.
- eng_mem_opdone  out  1  completion pulse to the engine.
- eng_mem_rdata  out  DWIDTH  read data to the engine.
- sram_en  out  1  SRAM access enable, active high.
- sram_we  out  1  SRAM write enable, qualified by sram_en.
- sram_addr  out  AWIDTH  SRAM address.
- sram_wdata  out  DWIDTH  SRAM write data.
- sram_rdata  in  DWIDTH  SRAM read data.
- grant  out  2  one-hot current owner: bit0 = wb, bit1 = eng; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - state goes to IDLE.
  - All outputs are 0: opdone, rdata, sram_*, grant, busy.
  - last_grant is set to eng, so the first tie goes to wb.
  - Any in-flight transaction is dropped with no opdone pulse.
- Op decode: 01 = read, 11 = write; 00 and 10 = no request. Code 10 is ignored and never granted.
- State machine: IDLE -> ISSUE -> (WAIT, reads only) -> DONE -> IDLE.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
  - On grant, latch that requester's op, addr and data, set grant, update last_grant, and go to ISSUE.
  - With no valid request, remain in IDLE.
- ISSUE (1 cycle):
  - sram_en = 1, sram_addr/sram_wdata from the latched values, sram_we = 1 for a write.
  - Next state is WAIT for a read, DONE for a write.
- WAIT:
  - sram_en = 0; a counter runs RD_LATENCY-1 cycles (0 cycles when RD_LATENCY = 1).
  - At the end, capture sram_rdata into the granted requester's rdata register, then go to DONE.
  - When RD_LATENCY = 1, the capture happens on the edge leaving WAIT, and WAIT lasts exactly 1 cycle.
- DONE (1 cycle): the granted requester's opdone = 1; next state is IDLE with grant cleared.
- Latency from the cycle the request is first seen in IDLE to the opdone cycle:
  - write: 2 cycles;
  - read: 2 + RD_LATENCY cycles.
- Back-to-back: the requester drops op to 00 on the edge that ends DONE, so the next IDLE cycle never re-grants the same transaction.
- sram_en is high for exactly one cycle per transaction.
- rdata per requester:
  - held until that requester's next read completes;
  - unaffected by writes and by the other requester's reads.
- Non-granted requester: its op is ignored until the arbiter returns to IDLE. No starvation — two consecutive contested grants always alternate.
- Op withdrawn or changed mid-transaction: a protocol violation. The latched transaction still completes and opdone still pulses.
- opdone is never asserted on both ports in the same cycle.

Test Plan:
- Reset then single write: wb_mem_op = 11, addr = 5, data = 0xDEADBEEF -> sram_en = sram_we = 1 one cycle later, sram_addr = 5; wb_mem_opdone pulses in the 3rd cycle; busy low afterward.
- Read with RD_LATENCY = 1: eng_mem_op = 01, addr = 5, SRAM model returns 0xDEADBEEF -> eng_mem_opdone in the 4th cycle, eng_mem_rdata = 0xDEADBEEF; wb_mem_rdata unchanged.
- Simultaneous requests from reset (wb read addr 1, eng write addr 2) -> wb granted first (grant = 01), then eng (grant = 10); held concurrent requests alternate wb, eng, wb, eng.
- RD_LATENCY = 3 read -> opdone 5 cycles after request; sram_en high for exactly 1 cycle.
- reset_n low during WAIT -> no opdone pulse; all outputs 0 the next cycle; the following tie grants wb.
- Op code 10 on wb alone -> no grant, busy stays 0, sram_en stays 0 for 10 cycles.
